// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer between NUM_REQ byte-beat requesters and one i2c_controller.
// Optional watchdog on START/BUSY/HOLD is enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no owner, round-robin scan of req_valid
// LOAD    | raise req_ready to the granted requester
// START   | take the beat while req_ready is up, then wait for ctrl_busy
// BUSY    | controller running the beat, wait for ctrl_done
// HOLD    | bus kept for the owner, next beat goes out with repeated start
// RELEASE | drop enable, remember owner for the next scan
module i2c_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
`ifdef I2C_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                   core_clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_addr,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_hold,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_done,
    output logic                   rsp_err,
    output logic [GW-1:0]          grant_idx,
    output logic                   ctrl_enable,
    output logic [7:0]             ctrl_slave_address,
    output logic [7:0]             ctrl_data_in,
    output logic                   ctrl_repeated_start,
    input  logic                   ctrl_busy,
    input  logic                   ctrl_done,
    input  logic                   ctrl_ack_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        last_q, last_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic                 hold_q, hold_d;
    logic                 from_hold_q, from_hold_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 en_q, en_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 rs_q, rs_d;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          tmr_q, tmr_d;
`endif

    logic                 sel_valid;
    logic                 sel_hold;
    logic [7:0]           sel_addr;
    logic [7:0]           sel_data;

    // First requester with valid set, scanning upward from the one after the last owner.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GW'((int'(last) + i) % NUM_REQ);
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_hold  = 1'b0;
        sel_addr  = 8'h00;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_hold  = req_hold[i];
                sel_addr  = req_addr[8*i +: 8];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        from_hold_d = from_hold_q;
        ready_d     = '0;
        done_d      = '0;
        err_d       = 1'b0;
        en_d        = en_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rs_d        = rs_q;
`ifdef I2C_ARB_TIMEOUT_EN
        tmr_d       = tmr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, last_q);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ready_d[grant_q] = 1'b1;
                state_d          = S_START;
            end
            S_START: begin
                // The accept edge is the one where the registered ready is visible.
                if (|ready_q) begin
                    if (sel_valid) begin
                        en_d   = 1'b1;
                        addr_d = sel_addr;
                        data_d = sel_data;
                        hold_d = sel_hold;
                        rs_d   = from_hold_q;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (ctrl_busy) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ctrl_done) begin
                    done_d[grant_q] = 1'b1;
                    err_d           = ctrl_ack_err;
                    state_d         = (hold_q && !ctrl_ack_err) ? S_HOLD : S_RELEASE;
                end
            end
            S_HOLD: begin
                if (sel_valid) begin
                    from_hold_d = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_RELEASE: begin
                en_d        = 1'b0;
                rs_d        = 1'b0;
                from_hold_d = 1'b0;
                last_d      = grant_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        if ((state_q == S_START || state_q == S_BUSY || state_q == S_HOLD) &&
            state_d == state_q && tmr_q == TMO_LAST) begin
            done_d          = '0;
            done_d[grant_q] = 1'b1;
            err_d           = 1'b1;
            state_d         = S_RELEASE;
        end
        if (state_d == S_START || state_d == S_BUSY || state_d == S_HOLD) begin
            tmr_d = (state_d != state_q) ? 16'd0 : tmr_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= GW'(NUM_REQ - 1);
            grant_q     <= '0;
            hold_q      <= 1'b0;
            from_hold_q <= 1'b0;
            ready_q     <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmr_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            from_hold_q <= from_hold_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
`ifdef I2C_ARB_TIMEOUT_EN
            tmr_q       <= tmr_d;
`endif
        end
    end

    assign req_ready           = ready_q;
    assign rsp_done            = done_q;
    assign rsp_err             = err_q;
    assign grant_idx           = grant_q;
    assign ctrl_enable         = en_q;
    assign ctrl_slave_address  = addr_q;
    assign ctrl_data_in        = data_q;
    assign ctrl_repeated_start = rs_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with two requesters and a behavioural controller stub.
module tb_i2c_req_arbiter;

    logic        core_clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_hold;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_done;
    logic        rsp_err;
    logic [0:0]  grant_idx;
    logic        ctrl_enable;
    logic [7:0]  ctrl_slave_address;
    logic [7:0]  ctrl_data_in;
    logic        ctrl_repeated_start;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        ctrl_ack_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    i2c_req_arbiter #(.NUM_REQ(2), .GW(1)) dut (
        .core_clk            (core_clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_hold            (req_hold),
        .req_ready           (req_ready),
        .rsp_done            (rsp_done),
        .rsp_err             (rsp_err),
        .grant_idx           (grant_idx),
        .ctrl_enable         (ctrl_enable),
        .ctrl_slave_address  (ctrl_slave_address),
        .ctrl_data_in        (ctrl_data_in),
        .ctrl_repeated_start (ctrl_repeated_start),
        .ctrl_busy           (ctrl_busy),
        .ctrl_done           (ctrl_done),
        .ctrl_ack_err        (ctrl_ack_err)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00; req_hold = 2'b00; req_addr = 16'h0; req_data = 16'h0;
        ctrl_busy = 1'b0; ctrl_done = 1'b0; ctrl_ack_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns at the negedge where a ready is seen; -1 when none shows up.
    task automatic wait_any_ready(output int who, output bit en_low);
        who = -1;
        en_low = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge core_clk);
            if (!ctrl_enable) en_low = 1'b1;
            if (req_ready[0]) begin who = 0; break; end
            if (req_ready[1]) begin who = 1; break; end
        end
    endtask

    // Controller stub: busy for a few cycles, one-cycle done; returns just after done was sampled.
    task automatic run_beat(input bit nack);
        tick();
        ctrl_busy = 1'b1;
        tick();
        tick();
        ctrl_done = 1'b1;
        ctrl_ack_err = nack;
        tick();
        ctrl_done = 1'b0;
        ctrl_ack_err = 1'b0;
        ctrl_busy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge core_clk);
        vec_cnt++;
        if ({req_ready, rsp_done, rsp_err, grant_idx, ctrl_enable, ctrl_slave_address,
             ctrl_data_in, ctrl_repeated_start} !== 26'h0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got ready=%b done=%b err=%b grant=%0d en=%b addr=%h data=%h rs=%b, want all 0",
                     req_ready, rsp_done, rsp_err, grant_idx, ctrl_enable, ctrl_slave_address,
                     ctrl_data_in, ctrl_repeated_start);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        req_valid = 2'b01; req_addr = 16'h00F0; req_data = 16'h0001; req_hold = 2'b00;
        @(negedge core_clk);
        @(negedge core_clk);
        vec_cnt++;
        if (req_ready !== 2'b00) begin
            miss_cnt++; $display("FAIL single_ready_early: got %b want 00", req_ready);
        end
        @(negedge core_clk);
        vec_cnt++;
        if (req_ready !== 2'b01 || ctrl_enable !== 1'b0) begin
            miss_cnt++; $display("FAIL single_ready_n2: got ready=%b en=%b want ready=01 en=0", req_ready, ctrl_enable);
        end
        @(negedge core_clk);
        vec_cnt++;
        if ({ctrl_enable, req_ready, grant_idx, ctrl_slave_address, ctrl_data_in, ctrl_repeated_start}
            !== {1'b1, 2'b00, 1'b0, 8'hF0, 8'h01, 1'b0}) begin
            miss_cnt++;
            $display("FAIL single_enable_n3: got en=%b ready=%b grant=%0d addr=%h data=%h rs=%b want en=1 ready=00 grant=0 addr=f0 data=01 rs=0",
                     ctrl_enable, req_ready, grant_idx, ctrl_slave_address, ctrl_data_in, ctrl_repeated_start);
        end
        req_valid = 2'b00;
        run_beat(1'b0);
        @(negedge core_clk);
        vec_cnt++;
        if (rsp_done !== 2'b01 || rsp_err !== 1'b0) begin
            miss_cnt++; $display("FAIL single_rsp: got done=%b err=%b want done=01 err=0", rsp_done, rsp_err);
        end
        @(negedge core_clk);
        vec_cnt++;
        if (rsp_done !== 2'b00 || ctrl_enable !== 1'b0) begin
            miss_cnt++; $display("FAIL single_release: got done=%b en=%b want done=00 en=0", rsp_done, ctrl_enable);
        end
    endtask

    task automatic test_contention();
        int who;
        bit en_low;
        do_reset();
        req_valid = 2'b11; req_addr = 16'hB2A1; req_data = 16'hD4C3; req_hold = 2'b00;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready(who, en_low);
            vec_cnt++;
            if (who !== (k % 2)) begin
                miss_cnt++; $display("FAIL contention_grant%0d: got requester %0d want %0d", k, who, k % 2);
            end
            tick();
            run_beat(1'b0);
            @(negedge core_clk);
            vec_cnt++;
            if (rsp_done !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                miss_cnt++; $display("FAIL contention_done%0d: got %b want %b", k, rsp_done,
                                     (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        req_valid = 2'b00;
        repeat (4) tick();
    endtask

    task automatic test_hold();
        int who;
        bit en_low;
        do_reset();
        req_valid = 2'b10; req_addr = 16'hA055; req_data = 16'h1166; req_hold = 2'b10;
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 1) begin
            miss_cnt++; $display("FAIL hold_first_grant: got %0d want 1", who);
        end
        tick();
        req_data = 16'h2266; req_hold = 2'b00; req_valid = 2'b11;
        run_beat(1'b0);
        @(negedge core_clk);
        vec_cnt++;
        if (rsp_done !== 2'b10 || rsp_err !== 1'b0) begin
            miss_cnt++; $display("FAIL hold_beat1_rsp: got done=%b err=%b want 10/0", rsp_done, rsp_err);
        end
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 1 || en_low !== 1'b0) begin
            miss_cnt++; $display("FAIL hold_sr_owner: got requester %0d enable_dropped=%b want 1/0", who, en_low);
        end
        tick();
        req_valid = 2'b01;
        @(negedge core_clk);
        vec_cnt++;
        if ({ctrl_enable, ctrl_repeated_start, ctrl_slave_address, ctrl_data_in} !== {1'b1, 1'b1, 8'hA0, 8'h22}) begin
            miss_cnt++;
            $display("FAIL hold_sr_beat: got en=%b rs=%b addr=%h data=%h want en=1 rs=1 addr=a0 data=22",
                     ctrl_enable, ctrl_repeated_start, ctrl_slave_address, ctrl_data_in);
        end
        run_beat(1'b0);
        @(negedge core_clk);
        vec_cnt++;
        if (rsp_done !== 2'b10) begin
            miss_cnt++; $display("FAIL hold_beat2_rsp: got %b want 10", rsp_done);
        end
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 0 || en_low !== 1'b1 || ctrl_repeated_start !== 1'b0) begin
            miss_cnt++; $display("FAIL hold_waiter_after_release: got requester %0d enable_dropped=%b rs=%b want 0/1/0",
                                 who, en_low, ctrl_repeated_start);
        end
        tick();
        req_valid = 2'b00;
        @(negedge core_clk);
        vec_cnt++;
        if (ctrl_repeated_start !== 1'b0 || ctrl_slave_address !== 8'h55) begin
            miss_cnt++; $display("FAIL hold_waiter_beat: got rs=%b addr=%h want rs=0 addr=55", ctrl_repeated_start, ctrl_slave_address);
        end
        run_beat(1'b0);
        repeat (3) tick();
    endtask

    task automatic test_nack();
        int who;
        bit en_low;
        do_reset();
        req_valid = 2'b11; req_addr = 16'h2010; req_data = 16'h4030; req_hold = 2'b01;
        wait_any_ready(who, en_low);
        tick();
        run_beat(1'b1);
        @(negedge core_clk);
        vec_cnt++;
        if (who !== 0 || rsp_done !== 2'b01 || rsp_err !== 1'b1) begin
            miss_cnt++; $display("FAIL nack_rsp: got requester %0d done=%b err=%b want 0/01/1", who, rsp_done, rsp_err);
        end
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 1 || en_low !== 1'b1) begin
            miss_cnt++; $display("FAIL nack_release: got next requester %0d enable_dropped=%b want 1/1", who, en_low);
        end
        tick();
        req_valid = 2'b00;
        @(negedge core_clk);
        vec_cnt++;
        if (ctrl_repeated_start !== 1'b0 || ctrl_slave_address !== 8'h20) begin
            miss_cnt++; $display("FAIL nack_next_beat: got rs=%b addr=%h want rs=0 addr=20", ctrl_repeated_start, ctrl_slave_address);
        end
        run_beat(1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset_in_busy();
        int who;
        bit en_low;
        bit done_seen;
        do_reset();
        req_valid = 2'b10; req_addr = 16'h7700; req_data = 16'h8800; req_hold = 2'b00;
        wait_any_ready(who, en_low);
        tick();
        ctrl_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge core_clk);
        vec_cnt++;
        if ({req_ready, rsp_done, rsp_err, grant_idx, ctrl_enable, ctrl_slave_address,
             ctrl_data_in, ctrl_repeated_start} !== 26'h0) begin
            miss_cnt++;
            $display("FAIL busy_reset_outputs: got ready=%b done=%b err=%b grant=%0d en=%b addr=%h data=%h rs=%b want all 0",
                     req_ready, rsp_done, rsp_err, grant_idx, ctrl_enable, ctrl_slave_address,
                     ctrl_data_in, ctrl_repeated_start);
        end
        done_seen = 1'b0;
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        ctrl_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge core_clk);
            if (rsp_done !== 2'b00 || ctrl_enable !== 1'b0) done_seen = 1'b1;
        end
        vec_cnt++;
        if (done_seen !== 1'b0) begin
            miss_cnt++; $display("FAIL busy_reset_dropped: got stray done/enable=%b want 0", done_seen);
        end
        req_valid = 2'b11;
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 0) begin
            miss_cnt++; $display("FAIL busy_reset_first_grant: got %0d want 0", who);
        end
        tick();
        req_valid = 2'b00;
        run_beat(1'b0);
        repeat (3) tick();
    endtask

    task automatic test_drop();
        int who;
        bit en_low;
        bit en_seen;
        do_reset();
        req_valid = 2'b01; req_addr = 16'h0033; req_data = 16'h0044; req_hold = 2'b00;
        wait_any_ready(who, en_low);
        req_valid = 2'b00;
        en_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge core_clk);
            if (ctrl_enable !== 1'b0 || rsp_done !== 2'b00) en_seen = 1'b1;
        end
        vec_cnt++;
        if (who !== 0 || en_seen !== 1'b0) begin
            miss_cnt++; $display("FAIL drop_no_beat: got requester %0d activity=%b want 0/0", who, en_seen);
        end
        req_valid = 2'b11;
        wait_any_ready(who, en_low);
        vec_cnt++;
        if (who !== 1) begin
            miss_cnt++; $display("FAIL drop_rr_advance: got %0d want 1", who);
        end
        tick();
        req_valid = 2'b00;
        run_beat(1'b0);
        repeat (3) tick();
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        localparam int TMO = 4096;
        int who;
        int cnt;
        bit en_low;
        do_reset();
        req_valid = 2'b01; req_addr = 16'h0011; req_data = 16'h0022; req_hold = 2'b00;
        wait_any_ready(who, en_low);
        tick();
        req_valid = 2'b00;
        cnt = -1;
        for (int k = 0; k < TMO + 16; k++) begin
            @(negedge core_clk);
            if (rsp_done !== 2'b00) begin cnt = k; break; end
        end
        vec_cnt++;
        if (cnt !== TMO - 1 || rsp_done !== 2'b01 || rsp_err !== 1'b1) begin
            miss_cnt++; $display("FAIL timeout_rsp: got cycle=%0d done=%b err=%b want cycle=%0d done=01 err=1",
                                 cnt, rsp_done, rsp_err, TMO - 1);
        end
        repeat (3) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_contention();
        test_hold();
        test_nack();
        test_reset_in_busy();
        test_drop();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit, want completion");
        $fatal(1);
    end

endmodule
